// File: rtl/ws2812_spectrum_sched.sv
`default_nettype none
// ============================================================================
// ws2812_spectrum_sched : FFT bins -> bar/peak-hold bitmap, double buffered,
// swapped into the driver-facing buffer on disp_sync.
// Optional macro WS2812_SERPENTINE_EN : odd rows column-reversed.
// Rev 1.0
// ============================================================================
module ws2812_spectrum_sched #(
    parameter int WS2812_M   = 8,
    parameter int WS2812_N   = 8,
    parameter int MAG_W      = 16,
    parameter int LVL_SHIFT  = 12,
    parameter int PEAK_DECAY = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bin_valid,
    output logic                         bin_ready,
    input  logic [MAG_W-1:0]             bin_mag,
    input  logic                         bin_last,
    input  logic                         disp_sync,
    output logic [WS2812_M*WS2812_N-1:0] arry_data,
    output logic [15:0]                  frame_cnt,
    output logic                         bin_err
);

    localparam int c_lvl_w  = $clog2(WS2812_M + 1);
    localparam int c_col_w  = (WS2812_N > 1) ? $clog2(WS2812_N) : 1;
    localparam int c_dcnt_w = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;
    localparam int c_bits   = WS2812_M * WS2812_N;

    localparam logic [c_col_w-1:0]  c_last_col   = c_col_w'(WS2812_N - 1);
    localparam logic [c_dcnt_w-1:0] c_decay_last = c_dcnt_w'(PEAK_DECAY - 1);
    localparam logic [c_lvl_w-1:0]  c_lvl_max    = c_lvl_w'(WS2812_M);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_BUILD   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [c_col_w-1:0]   r_col;
    logic [c_col_w-1:0]   r_bc;
    logic [c_lvl_w-1:0]   r_lvl  [WS2812_N];
    logic [c_lvl_w-1:0]   r_peak [WS2812_N];
    logic [c_bits-1:0]    r_back;
    logic [c_bits-1:0]    r_front;
    logic [15:0]          r_frame_cnt;
    logic                 r_bin_err;
    logic [c_dcnt_w-1:0]  r_dcnt;

    logic                 w_xfer;
    logic                 w_decay_now;
    logic [MAG_W-1:0]     w_shift;
    logic [c_lvl_w-1:0]   w_sat;
    logic [c_lvl_w-1:0]   w_lvl_c;
    logic [c_lvl_w-1:0]   w_peak_c;
    logic [c_lvl_w-1:0]   w_peak_new;
    logic [WS2812_M-1:0]  w_lit;
    logic [c_bits-1:0]    w_back_next;

    function automatic int bit_index(input int row, input int col);
`ifdef WS2812_SERPENTINE_EN
        return (row % 2 == 1) ? row * WS2812_N + (WS2812_N - 1 - col)
                              : row * WS2812_N + col;
`else
        return row * WS2812_N + col;
`endif
    endfunction

    // Ready is forced low while reset is held, even though the state is already COLLECT.
    assign bin_ready = (r_state == S_COLLECT) && rst_n;
    assign w_xfer    = bin_valid && bin_ready;

    // Saturate on the full-width shifted value so large magnitudes cannot alias.
    assign w_shift = bin_mag >> LVL_SHIFT;
    assign w_sat   = (w_shift > MAG_W'(WS2812_M)) ? c_lvl_max : w_shift[c_lvl_w-1:0];

    assign w_decay_now = (r_dcnt == c_decay_last);
    assign w_lvl_c     = r_lvl[r_bc];
    assign w_peak_c    = r_peak[r_bc];
    assign w_peak_new  = (w_lvl_c >= w_peak_c) ? w_lvl_c :
                         ((w_decay_now && (w_peak_c != '0)) ? w_peak_c - 1'b1 : w_peak_c);

    always_comb begin
        w_lit = '0;
        for (int r = 0; r < WS2812_M; r++) begin
            w_lit[r] = (c_lvl_w'(r) < w_lvl_c) ||
                       ((w_peak_new != '0) && (c_lvl_w'(r) == w_peak_new - 1'b1));
        end
    end

    always_comb begin
        w_back_next = r_back;
        for (int r = 0; r < WS2812_M; r++) begin
            w_back_next[bit_index(r, int'(r_bc))] = w_lit[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (w_xfer && (bin_last || (r_col == c_last_col))) w_state_next = S_BUILD;
            S_BUILD:   if (r_bc == c_last_col) w_state_next = S_PUBLISH;
            S_PUBLISH: if (disp_sync) w_state_next = S_COLLECT;
            default:   w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_bc        <= '0;
            r_back      <= '0;
            r_front     <= '0;
            r_frame_cnt <= '0;
            r_bin_err   <= 1'b0;
            r_dcnt      <= '0;
            for (int i = 0; i < WS2812_N; i++) begin
                r_lvl[i]  <= '0;
                r_peak[i] <= '0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_lvl[r_col] <= w_sat;
                        if (r_col == c_last_col) begin
                            r_col <= '0;
                            if (!bin_last) r_bin_err <= 1'b1;
                        end else if (bin_last) begin
                            // Short spectrum: blank the columns that never arrived.
                            r_col     <= '0;
                            r_bin_err <= 1'b1;
                            for (int i = 0; i < WS2812_N; i++) begin
                                if (c_col_w'(i) > r_col) r_lvl[i] <= '0;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_BUILD: begin
                    r_peak[r_bc] <= w_peak_new;
                    r_back       <= w_back_next;
                    r_bc         <= (r_bc == c_last_col) ? '0 : r_bc + 1'b1;
                end
                S_PUBLISH: begin
                    if (disp_sync) begin
                        r_front     <= r_back;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_dcnt      <= w_decay_now ? '0 : r_dcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arry_data = r_front;
    assign frame_cnt = r_frame_cnt;
    assign bin_err   = r_bin_err;

endmodule
`default_nettype wire
